ss_sch: RTL and testbench
=========================

SS_SCH -- requirements
Module: ss_sch

Interface
REQ-001 Parameter: NCH, 4, number of DMA channels sharing one ss_sgr engine (2..8).
REQ-002 Parameter: TMO, 1024, watchdog limit in cycles per service phase.
REQ-003 wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-004 wb_rst_n_i  in  1  reset, synchronous, active-low.
REQ-005 ch_req  in  NCH  per-channel service request, level.
REQ-006 ch_head  in  NCH*29  per-channel descriptor chain head, address bits [31:3]; channel i occupies [29*i+28:29*i].
REQ-007 ch_gnt  out  NCH  one-hot grant, held for the whole service.
REQ-008 ch_done  out  NCH  one-cycle completion pulse to the granted channel.
REQ-009 ch_err  out  NCH  one-cycle timeout pulse to the granted channel.
REQ-010 ch_next  out  29  sg_next captured at completion, valid while ch_done is high.
REQ-011 ds_ready  in  1  downstream consumer ready.
REQ-012 ss_we, ss_adr[1:0], ss_dat[31:0]  out  engine register write port.
REQ-013 ss_ready  out  1  ds_ready gated by a grant in RUN.
REQ-014 ss_done  out  1  one-cycle engine terminate strobe.
REQ-015 ss_xfer  in  1  engine transfer active.
REQ-016 sg_next  in  29  engine next-descriptor pointer [31:3].

Function
REQ-017 FSM states: IDLE, WR_PTR, WR_CTL, WAIT_X, RUN, FIN, ERR.
REQ-018 IDLE: when any ch_req is high, latch the round-robin winner and assert its ch_gnt in the next cycle; go to WR_PTR.
REQ-019 Round-robin: search starts at the channel after the last granted one; after reset the search starts at channel 0.
REQ-020 WR_PTR: drive ss_we=1, ss_adr=0, ss_dat={ch_head[winner],3'b000} for exactly one cycle; go to WR_CTL.
REQ-021 WR_CTL: drive ss_we=1, ss_adr=1, ss_dat=32'h1 (start) for exactly one cycle; go to WAIT_X.
REQ-022 WAIT_X: ss_xfer=1 moves to RUN.
REQ-023 RUN: ss_ready=ds_ready; ss_xfer=0 moves to FIN.
REQ-024 FIN, one cycle: ss_done=1, ch_done[winner]=1, ch_next=sg_next; then go to IDLE; ch_gnt drops with the return to IDLE.
REQ-025 Watchdog counter clears on every state entry; it counts each cycle in WAIT_X and RUN; reaching TMO-1 enters ERR.
REQ-026 RUN counter clears on every cycle in which ss_ready and ss_xfer are both high.
REQ-027 ERR, one cycle: ss_done=1, ch_err[winner]=1, ch_done=0; then go to IDLE.
REQ-028 Dropping ch_req after grant is ignored; the service runs to FIN or ERR.
REQ-029 A channel whose ch_req is still high at FIN is re-arbitrated normally and is not re-granted back-to-back if another channel requests.
REQ-030 Minimum IDLE-to-IDLE service time is 5 cycles.
REQ-031 Only one of ch_done and ch_err is ever high in a cycle, and it is the bit of the granted channel.
REQ-032 ss_we is high only in WR_PTR and WR_CTL.

Reset
REQ-033 When wb_rst_n_i=0 at a clock edge, the next cycle has: state=IDLE, all outputs 0, RR pointer=NCH-1 (so channel 0 has priority), watchdog=0.
REQ-034 Reset mid-service aborts the service without ss_done or ch_err.

Structure
REQ-035 Package ss_sch_pkg holds the state enum, the ss_adr constants (ADR_PTR=0, ADR_CTL=1), CTL_START=32'h1, and the NCH/TMO defaults.
REQ-036 Sub-module ss_rr_arb: combinational NCH-way round-robin picker with a registered pointer update enable, reused by other ss_* blocks.

Verification
REQ-037 Single request: ch_req=4'b0100, ch_head[2]=29'h100, engine asserts ss_xfer 3 cycles after start for 8 cycles -> writes 0x800 to adr0 and 0x1 to adr1, ch_done[2] pulse, ch_next=sg_next.
REQ-038 All four channels requesting continuously -> grant order 0,1,2,3,0 and no channel granted twice in a row.
REQ-039 ss_xfer never asserts, TMO=16 -> ch_err pulse 16 cycles after WAIT_X entry, ss_done=1 for one cycle, back to IDLE.
REQ-040 ds_ready=0 throughout RUN, TMO=16 -> ss_ready=0 and ch_err after 16 cycles; ds_ready toggling every cycle -> no timeout.
REQ-041 wb_rst_n_i=0 during RUN -> next cycle all outputs 0, no ch_done or ch_err; a later request with ch_req=4'b0010 grants channel 1 only after reset is released.

Source files
------------

// File: rtl/ss_sch_pkg.sv
// Shared types and constants for the ss_* scatter-gather scheduler family.
// Holds the scheduler state encoding, engine register map and parameter defaults.
package ss_sch_pkg;

  localparam int NCH_DEF = 4;
  localparam int TMO_DEF = 1024;

  localparam logic [1:0]  ADR_PTR   = 2'd0;
  localparam logic [1:0]  ADR_CTL   = 2'd1;
  localparam logic [31:0] CTL_START = 32'h1;

  typedef enum logic [2:0] {
    IDLE,
    WR_PTR,
    WR_CTL,
    WAIT_X,
    RUN,
    FIN,
    ERR
  } state_t;

endpackage

// File: rtl/ss_rr_arb.sv
// Round-robin picker: combinational winner search starting after the last
// granted channel; the pointer only moves when the owner commits a grant.
module ss_rr_arb import ss_sch_pkg::*; #(
  parameter int NCH = NCH_DEF,
  localparam int IW = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [NCH-1:0] req,
  input  logic          upd,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;

  function automatic logic [IW-1:0] cand(input logic [IW-1:0] p, input int k);
    return IW'((int'(p) + 1 + k) % NCH);
  endfunction

  // NOTE: every output gets a default before the search loop, otherwise
  // paths that find no requester would hold the old value and infer a latch.
  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int k = 0; k < NCH; k++) begin
      if (!any && req[cand(ptr, k)]) begin
        any = 1'b1;
        idx = cand(ptr, k);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order across always blocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= IW'(NCH - 1);
    end else if (upd) begin
      ptr <= idx;
    end
  end

endmodule

// File: rtl/ss_sch.sv
// Shares one ss_sgr engine between NCH DMA channels: arbitrates, programs the
// descriptor pointer and start bit, supervises the transfer with a watchdog.
module ss_sch import ss_sch_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*29-1:0] ch_head,
  output logic [NCH-1:0]    ch_gnt,
  output logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_err,
  output logic [28:0]       ch_next,
  input  logic              ds_ready,
  output logic              ss_we,
  output logic [1:0]        ss_adr,
  output logic [31:0]       ss_dat,
  output logic              ss_ready,
  output logic              ss_done,
  input  logic              ss_xfer,
  input  logic [28:0]       sg_next
);

  localparam int IW = $clog2(NCH);
  localparam int WW = $clog2(TMO);
  localparam logic [WW-1:0] WD_LIM = WW'(TMO - 1);

  state_t        state;
  logic [WW-1:0] wd;
  logic          arb_any;
  logic [IW-1:0] arb_idx;
  logic          arb_upd;
  logic [28:0]   win_head;

  assign arb_upd = (state == IDLE) && arb_any;

  ss_rr_arb #(.NCH(NCH)) u_arb (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .req   (ch_req),
    .upd   (arb_upd),
    .any   (arb_any),
    .idx   (arb_idx)
  );

  always_comb begin
    win_head = '0;
    for (int i = 0; i < NCH; i++) begin
      if (arb_idx == IW'(i)) win_head = ch_head[29*i +: 29];
    end
  end

  assign ss_ready = ds_ready && (state == RUN) && (|ch_gnt);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state   <= IDLE;
      wd      <= '0;
      ch_gnt  <= '0;
      ch_done <= '0;
      ch_err  <= '0;
      ch_next <= '0;
      ss_we   <= 1'b0;
      ss_adr  <= '0;
      ss_dat  <= '0;
      ss_done <= 1'b0;
    end else begin
      // Strobes and the write port are only ever high for one cycle.
      ss_we   <= 1'b0;
      ss_adr  <= '0;
      ss_dat  <= '0;
      ss_done <= 1'b0;
      ch_done <= '0;
      ch_err  <= '0;
      ch_next <= '0;
      case (state)
        IDLE: begin
          wd <= '0;
          if (arb_any) begin
            state  <= WR_PTR;
            ch_gnt <= NCH'(1) << arb_idx;
            ss_we  <= 1'b1;
            ss_adr <= ADR_PTR;
            ss_dat <= {win_head, 3'b000};
          end
        end
        WR_PTR: begin
          state  <= WR_CTL;
          ss_we  <= 1'b1;
          ss_adr <= ADR_CTL;
          ss_dat <= CTL_START;
        end
        WR_CTL: begin
          state <= WAIT_X;
          wd    <= '0;
        end
        WAIT_X: begin
          if (ss_xfer) begin
            state <= RUN;
            wd    <= '0;
          end else if (wd == WD_LIM) begin
            state   <= ERR;
            wd      <= '0;
            ss_done <= 1'b1;
            ch_err  <= ch_gnt;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RUN: begin
          // Completion wins over a timeout that expires in the same cycle.
          if (!ss_xfer) begin
            state   <= FIN;
            wd      <= '0;
            ss_done <= 1'b1;
            ch_done <= ch_gnt;
            ch_next <= sg_next;
          end else if (ss_ready) begin
            wd <= '0;
          end else if (wd == WD_LIM) begin
            state   <= ERR;
            wd      <= '0;
            ss_done <= 1'b1;
            ch_err  <= ch_gnt;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        FIN, ERR: begin
          state  <= IDLE;
          wd     <= '0;
          ch_gnt <= '0;
        end
        default: begin
          state  <= IDLE;
          wd     <= '0;
          ch_gnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ss_sch.sv
// Self-checking bench for ss_sch: table-driven services checked against a
// timing model, with a scoreboard of expected engine writes and completions.
module tb_ss_sch;

  localparam int NCH = 4;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              wb_rst_n_i;
  logic [NCH-1:0]    ch_req;
  logic [NCH*29-1:0] ch_head;
  logic [NCH-1:0]    ch_gnt, ch_done, ch_err;
  logic [28:0]       ch_next;
  logic              ds_ready;
  logic              ss_we;
  logic [1:0]        ss_adr;
  logic [31:0]       ss_dat;
  logic              ss_ready;
  logic              ss_done;
  logic              ss_xfer;
  logic [28:0]       sg_next;

  ss_sch #(.NCH(NCH), .TMO(TMO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (wb_rst_n_i),
    .ch_req     (ch_req),
    .ch_head    (ch_head),
    .ch_gnt     (ch_gnt),
    .ch_done    (ch_done),
    .ch_err     (ch_err),
    .ch_next    (ch_next),
    .ds_ready   (ds_ready),
    .ss_we      (ss_we),
    .ss_adr     (ss_adr),
    .ss_dat     (ss_dat),
    .ss_ready   (ss_ready),
    .ss_done    (ss_done),
    .ss_xfer    (ss_xfer),
    .sg_next    (sg_next)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_WR, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e       kind;
    logic [1:0]     adr;
    logic [31:0]    dat;
    logic [NCH-1:0] gnt;
  } ev_t;

  // mode: 0 = ds_ready high, 1 = ds_ready low, 2 = ds_ready toggles
  typedef struct {
    logic [NCH-1:0] req;
    bit             hold;
    logic [28:0]    head;
    int             delay;
    int             len;
    int             mode;
    int             ch;
  } vec_t;

  ev_t  sb[$];
  ev_t  mon_e;
  vec_t tv[14];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [1:0] adr, input logic [31:0] dat);
    ev_t e;
    e.kind = EV_WR; e.adr = adr; e.dat = dat; e.gnt = '0;
    sb.push_back(e);
  endtask

  // Expected outcome and timing, offsets counted from the WR_CTL cycle.
  function automatic void model(input vec_t v, output bit err, output int off, output int run_lo);
    if (v.len == 0 || v.delay > TMO) begin
      err = 1'b1; off = TMO + 1; run_lo = off;
    end else begin
      run_lo = v.delay + 1;
      if (v.mode == 1 && v.len > TMO) begin
        err = 1'b1; off = v.delay + 1 + TMO;
      end else begin
        err = 1'b0; off = v.delay + v.len + 1;
      end
    end
  endfunction

  task automatic serve(input vec_t v);
    bit             exp_err;
    int             exp_off, run_lo, off;
    logic [NCH-1:0] exp_gnt;
    logic [28:0]    hd, nxt;
    logic           exp_rdy;
    ev_t            e;
    model(v, exp_err, exp_off, run_lo);
    exp_gnt = NCH'(1) << v.ch;
    for (int i = 0; i < NCH; i++) ch_head[29*i +: 29] = 29'($urandom);
    if (v.head != '0) ch_head[29*v.ch +: 29] = v.head;
    hd      = ch_head[29*v.ch +: 29];
    nxt     = 29'($urandom);
    sg_next = nxt;
    ch_req  = v.req;
    ss_xfer = 1'b0;
    ds_ready = 1'b0;
    push_wr(2'd0, {hd, 3'b000});
    push_wr(2'd1, 32'h1);
    e.kind = exp_err ? EV_ERR : EV_DONE; e.adr = '0; e.dat = {3'b000, nxt}; e.gnt = exp_gnt;
    sb.push_back(e);
    tick();
    check("grant", ch_gnt, exp_gnt);
    if (!v.hold) ch_req = '0;
    tick();
    off = -1;
    for (int c = 0; c < 200; c++) begin
      ss_xfer  = (c >= v.delay) && (c < v.delay + v.len);
      ds_ready = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? 1'b0 : (c % 2 == 1);
      #1;
      exp_rdy = (c >= run_lo) && (c < exp_off) && ds_ready;
      check("ss_ready", ss_ready, exp_rdy);
      tick();
      if (off < 0 && (ch_done != '0 || ch_err != '0)) off = c + 1;
      if (ch_gnt == '0) break;
    end
    ss_xfer  = 1'b0;
    ds_ready = 1'b0;
    check("end_offset", off, exp_off);
    check("gnt_released", ch_gnt, '0);
  endtask

  // Scoreboard side: every engine write and every completion pulse pops one entry.
  always @(negedge clk) begin
    if (ss_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_empty_on_write", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_kind", mon_e.kind == EV_WR, 1);
        check("wr_adr", ss_adr, mon_e.adr);
        check("wr_dat", ss_dat, mon_e.dat);
      end
    end
    if (ss_done === 1'b1 || (ch_done !== '0 && ch_done !== 'x) || (ch_err !== '0 && ch_err !== 'x)) begin
      if (sb.size() == 0) begin
        check("sb_empty_on_pulse", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("ss_done", ss_done, 1);
        check("ch_done", ch_done, (mon_e.kind == EV_DONE) ? mon_e.gnt : '0);
        check("ch_err", ch_err, (mon_e.kind == EV_ERR) ? mon_e.gnt : '0);
        if (mon_e.kind == EV_DONE) check("ch_next", ch_next, mon_e.dat[28:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish by %0t", $time);
    $fatal(1, "bench timeout");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, ch_gnt, '0);
    check({tag, "_done"}, ch_done, '0);
    check({tag, "_err"}, ch_err, '0);
    check({tag, "_next"}, ch_next, '0);
    check({tag, "_we"}, ss_we, 0);
    check({tag, "_adr"}, ss_adr, '0);
    check({tag, "_dat"}, ss_dat, '0);
    check({tag, "_ready"}, ss_ready, 0);
    check({tag, "_ssdone"}, ss_done, 0);
  endtask

  initial begin
    vec_t rv;
    logic [28:0] hd;
    //        req      hold  head     dly len mode ch
    tv[0]  = '{4'b1111, 1'b1, 29'h0,    1,  2, 0, 0};
    tv[1]  = '{4'b1111, 1'b1, 29'h0,    1,  2, 0, 1};
    tv[2]  = '{4'b1111, 1'b1, 29'h0,    1,  2, 0, 2};
    tv[3]  = '{4'b1111, 1'b1, 29'h0,    2,  3, 0, 3};
    tv[4]  = '{4'b1111, 1'b1, 29'h0,    1,  1, 0, 0};
    tv[5]  = '{4'b0100, 1'b0, 29'h100,  3,  8, 0, 2};
    tv[6]  = '{4'b0011, 1'b0, 29'h0,   40,  0, 0, 0};
    tv[7]  = '{4'b0001, 1'b0, 29'h0,    1, 30, 1, 0};
    tv[8]  = '{4'b0010, 1'b0, 29'h0,    1, 40, 2, 1};
    tv[9]  = '{4'b0001, 1'b0, 29'h0,   16,  2, 0, 0};
    tv[10] = '{4'b1000, 1'b0, 29'h0,   17,  4, 0, 3};
    tv[11] = '{4'b0101, 1'b0, 29'h0,    2, 16, 1, 0};
    tv[12] = '{4'b0101, 1'b0, 29'h0,    2, 17, 1, 2};
    tv[13] = '{4'b1001, 1'b0, 29'h0,    1, 20, 0, 3};

    wb_rst_n_i = 1'b0;
    ch_req     = '1;
    ch_head    = '0;
    ds_ready   = 1'b1;
    ss_xfer    = 1'b0;
    sg_next    = '0;
    tick();
    tick();
    check_all_zero("reset");
    ch_req     = '0;
    ds_ready   = 1'b0;
    wb_rst_n_i = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) serve(tv[i]);

    // Reset in the middle of a RUN phase aborts without any completion pulse.
    for (int i = 0; i < NCH; i++) ch_head[29*i +: 29] = 29'($urandom);
    hd = ch_head[29*2 +: 29];
    ch_req = 4'b0100;
    push_wr(2'd0, {hd, 3'b000});
    push_wr(2'd1, 32'h1);
    tick();
    check("rst_seq_grant", ch_gnt, 4'b0100);
    tick();
    ss_xfer  = 1'b1;
    ds_ready = 1'b1;
    tick();
    tick();
    check("rst_seq_run_ready", ss_ready, 1);
    wb_rst_n_i = 1'b0;
    ch_req     = 4'b0010;
    tick();
    check_all_zero("mid_reset");
    tick();
    check("held_reset_gnt", ch_gnt, '0);
    ss_xfer    = 1'b0;
    ds_ready   = 1'b0;
    wb_rst_n_i = 1'b1;
    rv = '{4'b0010, 1'b0, 29'h0, 1, 3, 0, 1};
    serve(rv);

    tick();
    tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
